// File: rtl/ultrasound_pkg.sv
// Shared widths, constants, state encoding and small helpers for the ultrasound sweep scheduler.
package ultrasound_pkg;

    localparam int R_W     = 8;
    localparam int THETA_W = 4;
    localparam int LOC_W   = 12;

    localparam logic [R_W-1:0] R_NONE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FIRE      = 3'd1,
        WAIT_ECHO = 3'd2,
        SETTLE    = 3'd3,
        REPORT    = 3'd4
    } us_state_e;

    // Mean of two ranges through a 9-bit sum so the carry is not lost.
    function automatic logic [R_W-1:0] avg_r(input logic [R_W-1:0] a, input logic [R_W-1:0] b);
        logic [R_W:0] sum_v;
        sum_v = {1'b0, a} + {1'b0, b};
        return sum_v[R_W:1];
    endfunction

    function automatic logic [LOC_W-1:0] pack_loc(input logic [THETA_W-1:0] theta, input logic [R_W-1:0] r);
        return {theta, r};
    endfunction

endpackage

// File: rtl/us_interval_timer.sv
// Count-to-terminal interval timer; tc is high while enabled and the count equals load_value.
module us_interval_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] load_value,
    output logic             tc
);

    logic [CNT_W-1:0] count_r;

    // Counter: cleared on request, otherwise advances while enabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = enable && (count_r == load_value);

endmodule

// File: rtl/ultrasound_scheduler.sv
// Sweeps one ranging driver across NUM_SENSORS positions and reports the nearest {theta, r}.
// Optional ULTRASOUND_AVG_EN: two shots per sensor, averaged before the nearest-range compare.
module ultrasound_scheduler
    import ultrasound_pkg::*;
#(
    parameter int NUM_SENSORS    = 12,
    parameter int TIMEOUT_CYCLES = 1350000,
    parameter int SETTLE_CYCLES  = 270000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic               echo_done,
    input  logic               echo_valid,
    input  logic [R_W-1:0]     echo_distance,
    output logic               trigger,
    output logic [THETA_W-1:0] sensor_select,
    output logic               busy,
    output logic               done,
    output logic [LOC_W-1:0]   location,
    output logic               found
);

    localparam int MAX_CYC = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [THETA_W-1:0] LAST_IDX     = THETA_W'(NUM_SENSORS - 1);

    us_state_e          state_r, next_state_s;
    logic [THETA_W-1:0] index_r, index_next_s;
    logic [R_W-1:0]     best_dist_r;
    logic [THETA_W-1:0] best_theta_r;
    logic               found_int_r;
    logic               trigger_r, busy_r, done_r, found_r;
    logic [LOC_W-1:0]   location_r;
    logic               timer_clear_s, timer_en_s, timer_tc_s;
    logic [CNT_W-1:0]   timer_last_s;
    logic               start_sweep_s, echo_ok_s, wait_exit_s;
    logic               cand_valid_s;
    logic [R_W-1:0]     cand_r_s;
`ifdef ULTRASOUND_AVG_EN
    logic               shot_r, shot_next_s;
    logic               d0_valid_r;
    logic [R_W-1:0]     d0_dist_r;
`endif

    assign start_sweep_s = (state_r == IDLE) && start && !abort;
    assign echo_ok_s     = echo_done && echo_valid && (echo_distance != 8'd0);
    assign wait_exit_s   = (state_r == WAIT_ECHO) && !abort && (echo_done || timer_tc_s);

    // Next-state, sensor index and shot sequencing; abort returns any active state to IDLE.
    always_comb begin
        next_state_s = state_r;
        index_next_s = index_r;
`ifdef ULTRASOUND_AVG_EN
        shot_next_s  = shot_r;
`endif
        case (state_r)
            IDLE: begin
                if (start_sweep_s) begin
                    next_state_s = FIRE;
                    index_next_s = 4'd0;
`ifdef ULTRASOUND_AVG_EN
                    shot_next_s  = 1'b0;
`endif
                end else begin
                    next_state_s = IDLE;
                end
            end
            FIRE: begin
                if (abort) next_state_s = IDLE;
                else       next_state_s = WAIT_ECHO;
            end
            WAIT_ECHO: begin
                if (abort)            next_state_s = IDLE;
                else if (wait_exit_s) next_state_s = SETTLE;
                else                  next_state_s = WAIT_ECHO;
            end
            SETTLE: begin
                if (abort) begin
                    next_state_s = IDLE;
                end else if (timer_tc_s) begin
`ifdef ULTRASOUND_AVG_EN
                    if (!shot_r) begin
                        next_state_s = FIRE;
                        shot_next_s  = 1'b1;
                    end else if (index_r == LAST_IDX) begin
                        next_state_s = REPORT;
                        shot_next_s  = 1'b0;
                    end else begin
                        next_state_s = FIRE;
                        index_next_s = index_r + 4'd1;
                        shot_next_s  = 1'b0;
                    end
`else
                    if (index_r == LAST_IDX) begin
                        next_state_s = REPORT;
                    end else begin
                        next_state_s = FIRE;
                        index_next_s = index_r + 4'd1;
                    end
`endif
                end else begin
                    next_state_s = SETTLE;
                end
            end
            REPORT:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Candidate range for this sensor, offered once when its final wait ends.
    always_comb begin
        cand_valid_s = 1'b0;
        cand_r_s     = R_NONE;
`ifdef ULTRASOUND_AVG_EN
        if (wait_exit_s && shot_r) begin
            if (echo_ok_s && d0_valid_r) begin
                cand_valid_s = 1'b1;
                cand_r_s     = avg_r(d0_dist_r, echo_distance);
            end else if (echo_ok_s) begin
                cand_valid_s = 1'b1;
                cand_r_s     = echo_distance;
            end else if (d0_valid_r) begin
                cand_valid_s = 1'b1;
                cand_r_s     = d0_dist_r;
            end else begin
                cand_valid_s = 1'b0;
            end
        end else begin
            cand_valid_s = 1'b0;
        end
`else
        if (wait_exit_s && echo_ok_s) begin
            cand_valid_s = 1'b1;
            cand_r_s     = echo_distance;
        end else begin
            cand_valid_s = 1'b0;
        end
`endif
    end

    // One timer serves both the echo timeout and the settle gap; it restarts on every state change.
    always_comb begin
        timer_clear_s = (next_state_s != state_r);
        timer_en_s    = (state_r == WAIT_ECHO) || (state_r == SETTLE);
        if (state_r == WAIT_ECHO) timer_last_s = TIMEOUT_LAST;
        else                      timer_last_s = SETTLE_LAST;
    end

    us_interval_timer #(.CNT_W(CNT_W)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (timer_clear_s),
        .enable     (timer_en_s),
        .load_value (timer_last_s),
        .tc         (timer_tc_s)
    );

    // State, nearest-target tracking and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            index_r      <= 4'd0;
            best_dist_r  <= R_NONE;
            best_theta_r <= 4'd0;
            found_int_r  <= 1'b0;
            trigger_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            location_r   <= 12'h000;
            found_r      <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            index_r   <= index_next_s;
            trigger_r <= (next_state_s == FIRE);
            busy_r    <= (next_state_s != IDLE);
            done_r    <= (next_state_s == REPORT);
            if (start_sweep_s) begin
                best_dist_r  <= R_NONE;
                best_theta_r <= 4'd0;
                found_int_r  <= 1'b0;
            end else if (cand_valid_s && (cand_r_s < best_dist_r)) begin
                best_dist_r  <= cand_r_s;
                best_theta_r <= index_r;
                found_int_r  <= 1'b1;
            end else begin
                best_dist_r  <= best_dist_r;
            end
            if (next_state_s == REPORT) begin
                location_r <= found_int_r ? pack_loc(best_theta_r, best_dist_r) : 12'h000;
                found_r    <= found_int_r;
            end else begin
                location_r <= location_r;
            end
        end
    end

`ifdef ULTRASOUND_AVG_EN
    // Shot selector and first-shot capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shot_r     <= 1'b0;
            d0_valid_r <= 1'b0;
            d0_dist_r  <= 8'd0;
        end else begin
            shot_r <= shot_next_s;
            if (wait_exit_s && !shot_r) begin
                d0_valid_r <= echo_ok_s;
                d0_dist_r  <= echo_distance;
            end else begin
                d0_valid_r <= d0_valid_r;
            end
        end
    end
`endif

    assign trigger       = trigger_r;
    assign sensor_select = index_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign location      = location_r;
    assign found         = found_r;

endmodule

// File: tb/tb_ultrasound_scheduler.sv
// Scoreboard bench for ultrasound_scheduler: sweeps push expected {found, location}, a monitor checks each done.
module tb_ultrasound_scheduler;

    localparam int NS = 4;
    localparam int TO = 100;
    localparam int ST = 10;
`ifdef ULTRASOUND_AVG_EN
    localparam int SHOTS = 2;
`else
    localparam int SHOTS = 1;
`endif
    localparam int NT = NS * SHOTS;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, echo_done = 1'b0, echo_valid = 1'b0;
    logic [7:0]  echo_distance = 8'd0;
    logic        trigger, busy, done, found;
    logic [3:0]  sensor_select;
    logic [11:0] location;

    int checks = 0, errors = 0;
    int trig_cnt = 0, done_cnt = 0, done_cyc = 0, cyc_cnt = 0;
    logic [12:0] exp_q[$];

    logic [7:0] dist_t [8];
    logic       vld_t  [8];
    logic       rsp_t  [8];

    ultrasound_scheduler #(.NUM_SENSORS(NS), .TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(ST)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .echo_done(echo_done), .echo_valid(echo_valid), .echo_distance(echo_distance),
        .trigger(trigger), .sensor_select(sensor_select), .busy(busy), .done(done),
        .location(location), .found(found)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    // Monitor: counts triggers and checks every done against the scoreboard.
    always @(negedge clock) begin
        logic [12:0] e;
        if (reset_n) begin
            if (trigger) trig_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc_cnt;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got found=%0b location=%03h, no done expected", found, location);
                end else begin
                    e = exp_q.pop_front();
                    if ({found, location} !== e)begin
                        errors++;
                        $display("FAIL report: got found=%0b location=%03h expected found=%0b location=%03h",
                                 found, location, e[12], e[11:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic load4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                         input logic [3:0] v, input logic [3:0] r);
        dist_t[0] = a; dist_t[1] = b; dist_t[2] = c; dist_t[3] = d;
        for (int i = 0; i < 4; i++) begin
            vld_t[i] = v[i];
            rsp_t[i] = r[i];
        end
    endtask

    task automatic pulse_start(output int c_s);
        start = 1'b1;
        c_s = cyc_cnt;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_trig();
        int n = 0;
        while (!trigger && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!trigger) begin
            checks++;
            errors++;
            $display("FAIL trigger_timeout: got no trigger in %0d cycles, required one", n);
        end
    endtask

    // Serve one fire: check the selected sensor, then answer from the tables.
    task automatic serve(input int k, input int stray_at, input int start_at);
        wait_trig();
        chk($sformatf("sensor_select_%0d", k), 32'(sensor_select), 32'(k / SHOTS));
        cyc(2);
        if (k == start_at) start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        if (rsp_t[k]) begin
            echo_done = 1'b1; echo_valid = vld_t[k]; echo_distance = dist_t[k];
            cyc(1);
            echo_done = 1'b0; echo_valid = 1'b0; echo_distance = 8'd0;
        end
        if (k == stray_at) begin
            cyc(3);
            echo_done = 1'b1; echo_valid = 1'b1; echo_distance = 8'd5;
            cyc(1);
            echo_done = 1'b0; echo_valid = 1'b0; echo_distance = 8'd0;
        end
    endtask

    task automatic run_sweep(input string name, input logic [11:0] exp_loc, input logic exp_found,
                             input int stray_at, input int start_at, output int lat);
        int t0, d0, c_s, n;
        t0 = trig_cnt;
        d0 = done_cnt;
        exp_q.push_back({exp_found, exp_loc});
        pulse_start(c_s);
        for (int k = 0; k < NT; k++) serve(k, stray_at, start_at);
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        lat = done_cyc - c_s + 1;
        cyc(20);
        chk({name, "_triggers"}, 32'(trig_cnt - t0), 32'(NT));
        chk({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat, c_s, t0, d0;
        cyc(3);
        chk("reset_trigger", 32'(trigger), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sel", 32'(sensor_select), 32'd0);
        chk("reset_loc", {19'd0, found, location}, 32'd0);
        reset_n = 1'b1;
        cyc(2);
`ifdef ULTRASOUND_AVG_EN
        for (int i = 0; i < 8; i++) begin
            dist_t[i] = 8'd0; vld_t[i] = 1'b0; rsp_t[i] = 1'b0;
        end
        dist_t[0] = 8'd20; vld_t[0] = 1'b1; rsp_t[0] = 1'b1;
        dist_t[1] = 8'd31; vld_t[1] = 1'b1; rsp_t[1] = 1'b1;
        run_sweep("avg", 12'h019, 1'b1, -1, -1, lat);
`else
        load4(8'd40, 8'd25, 8'd60, 8'd30, 4'b1111, 4'b1111);
        run_sweep("nearest", 12'h119, 1'b1, -1, -1, lat);
        load4(8'd90, 8'd25, 8'd90, 8'd25, 4'b1111, 4'b1111);
        run_sweep("tie", 12'h119, 1'b1, -1, -1, lat);
        load4(8'd0, 8'd200, 8'd255, 8'd201, 4'b1111, 4'b1111);
        run_sweep("zero_ff", 12'h1C8, 1'b1, -1, -1, lat);
        load4(8'd50, 8'd70, 8'd10, 8'd60, 4'b1011, 4'b1111);
        run_sweep("controls", 12'h032, 1'b1, 0, 1, lat);

        // Abort during sensor 2 wait: idle next cycle, no done, previous report held.
        t0 = trig_cnt;
        d0 = done_cnt;
        pulse_start(c_s);
        serve(0, -1, -1);
        serve(1, -1, -1);
        wait_trig();
        cyc(3);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        cyc(150);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_triggers", 32'(trig_cnt - t0), 32'd3);
        chk("abort_loc_held", {19'd0, found, location}, {19'd0, 1'b1, 12'h032});

        load4(8'd40, 8'd25, 8'd60, 8'd30, 4'b1111, 4'b1111);
        run_sweep("after_abort", 12'h119, 1'b1, -1, -1, lat);

        // Asynchronous reset in the middle of a settle gap.
        d0 = done_cnt;
        pulse_start(c_s);
        serve(0, -1, -1);
        cyc(3);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_loc", {19'd0, found, location}, 32'd0);
        chk("rst_trig_sel", {27'd0, trigger, sensor_select}, 32'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(150);
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);

        load4(8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 4'b0000);
        run_sweep("timeout", 12'h000, 1'b0, -1, -1, lat);
        chk("timeout_latency", 32'(lat), 32'(NS * (1 + TO + ST) + 2));
`endif
        cyc(5);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
